// File: rtl/jk_bank_pkg.sv
// jk_bank_pkg: shared definitions for the JK bit bank arbiter.
//   - state_e      : arbiter/command FSM states
//   - JK_*         : two-bit {J,K} command encodings
//   - DEF_NBITS    : default bank width
//   - CMD_*        : command field positions. A command is {bcast, J, K, idx};
//                    idx sits at the bottom, the single-bit fields are given
//                    as offsets above the idx field (which is IDXW wide).
package jk_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    localparam int DEF_NBITS = 8;

    localparam int CMD_IDX_LSB   = 0;
    localparam int CMD_K_OFS     = 0;
    localparam int CMD_J_OFS     = 1;
    localparam int CMD_BCAST_OFS = 2;

    // Total command width for a given index width.
    function automatic int cmd_width(input int idxw);
        return idxw + 3;
    endfunction

endpackage

// File: rtl/jk_bit_cell.sv
// jk_bit_cell: one JK storage bit with a write enable.
// Ports:
//   clk_i  - clock, rising edge
//   rst_ni - asynchronous active-low reset, clears the bit
//   en_i   - apply {j_i,k_i} on this edge; otherwise hold
//   j_i    - J input
//   k_i    - K input
//   q_o    - stored bit
module jk_bit_cell
    import jk_bank_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);

    logic q_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= 1'b0;
        end else if (en_i) begin
            case ({j_i, k_i})
                JK_HOLD: q_q <= q_q;
                JK_CLR:  q_q <= 1'b0;
                JK_SET:  q_q <= 1'b1;
                JK_TGL:  q_q <= ~q_q;
                default: q_q <= q_q;
            endcase
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/jk_bank_arb.sv
// jk_bank_arb: two-requester round-robin front end to a bank of NBITS JK bits.
// A command {bcast, J, K, idx} is accepted in IDLE, applied one cycle later
// (APPLY), and acknowledged with a one-cycle done pulse to its owner (DONE).
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   req_valid  - per-requester command valid
//   req_ready  - per-requester accept (combinational, only in IDLE)
//   req_cmd0/1 - commands {bcast, J, K, idx}
//   done       - one-cycle completion pulse to the owning requester
//   err        - qualifies done: non-broadcast command with idx >= NBITS
//   q          - bank contents
//   busy       - FSM not in IDLE
module jk_bank_arb
    import jk_bank_pkg::*;
#(
    parameter int NBITS = DEF_NBITS,
    parameter int IDXW  = $clog2(NBITS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [IDXW+2:0]   req_cmd0,
    input  logic [IDXW+2:0]   req_cmd1,
    output logic [1:0]        done,
    output logic              err,
    output logic [NBITS-1:0]  q,
    output logic              busy
);

    localparam int CMDW      = cmd_width(IDXW);
    localparam int K_BIT     = IDXW + CMD_K_OFS;
    localparam int J_BIT     = IDXW + CMD_J_OFS;
    localparam int BCAST_BIT = IDXW + CMD_BCAST_OFS;

    state_e            state_q;
    logic              last_q;      // index of the requester granted most recently
    logic              owner_q;     // requester owning the command in flight
    logic [CMDW-1:0]   cmd_q;
    logic [CMDW-1:0]   cmd_d;
    logic [1:0]        gnt_d;
    logic [1:0]        done_q;
    logic              err_q;
    logic [31:0]       idx_ext;
    logic              idx_oob;
    logic [NBITS-1:0]  bit_en;

    // Round-robin grant, only offered while IDLE. On a tie the requester
    // that did not win last time is granted.
    always_comb begin
        gnt_d = 2'b00;
        if (state_q == IDLE) begin
            case (req_valid)
                2'b01:   gnt_d = 2'b01;
                2'b10:   gnt_d = 2'b10;
                2'b11:   gnt_d = last_q ? 2'b01 : 2'b10;
                default: gnt_d = 2'b00;
            endcase
        end
    end

    assign req_ready = gnt_d;
    assign cmd_d     = gnt_d[1] ? req_cmd1 : req_cmd0;

    // IDXW may be wider than needed so that out-of-range indices are
    // representable; compare at full width.
    assign idx_ext = 32'(cmd_q[CMD_IDX_LSB +: IDXW]);
    assign idx_oob = (idx_ext >= 32'(NBITS));

    // Bit enables are only live during APPLY, so the bank updates on the
    // edge that ends APPLY. An out-of-range index matches no bit.
    always_comb begin
        bit_en = '0;
        if (state_q == APPLY) begin
            for (int i = 0; i < NBITS; i++) begin
                bit_en[i] = cmd_q[BCAST_BIT] || (idx_ext == 32'(i));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            cmd_q   <= '0;
            done_q  <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 2'b00;
                    err_q  <= 1'b0;
                    if (gnt_d != 2'b00) begin
                        cmd_q   <= cmd_d;
                        owner_q <= gnt_d[1];
                        last_q  <= gnt_d[1];
                        state_q <= APPLY;
                    end
                end
                APPLY: begin
                    done_q  <= owner_q ? 2'b10 : 2'b01;
                    err_q   <= !cmd_q[BCAST_BIT] && idx_oob;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 2'b00;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 2'b00;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign done = done_q;
    assign err  = err_q;
    assign busy = (state_q != IDLE);

    for (genvar g = 0; g < NBITS; g++) begin : g_cell
        jk_bit_cell u_cell (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .en_i   (bit_en[g]),
            .j_i    (cmd_q[J_BIT]),
            .k_i    (cmd_q[K_BIT]),
            .q_o    (q[g])
        );
    end

endmodule

// File: tb/tb_jk_bank_arb.sv
module tb_jk_bank_arb;

    localparam int NB = 8;
    localparam int IW = 4;   // one bit wider than needed so idx 8..15 exist
    localparam int CW = IW + 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [CW-1:0]  req_cmd0;
    logic [CW-1:0]  req_cmd1;
    logic [1:0]     done;
    logic           err;
    logic [NB-1:0]  q;
    logic           busy;

    always #5 clk = ~clk;

    jk_bank_arb #(.NBITS(NB), .IDXW(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd0  (req_cmd0),
        .req_cmd1  (req_cmd1),
        .done      (done),
        .err       (err),
        .q         (q),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: bank value, round-robin memory, and how many cycles
    // have passed since the command in flight was accepted (0 = none).
    logic [NB-1:0]  m_bank;
    logic           m_last;
    int             m_phase;
    logic           m_own;
    logic [CW-1:0]  m_cmd;
    logic [1:0]     m_gnt;
    logic [1:0]     obs_ready;
    logic [1:0]     obs_log[$];

    function automatic logic [CW-1:0] mk(input bit b, input bit j, input bit k, input int idx);
        return {b, j, k, IW'(idx)};
    endfunction

    function automatic logic [CW-1:0] rand_cmd();
        bit b;
        b = ($urandom_range(0, 7) == 0);
        return mk(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 9)));
    endfunction

    function automatic logic [NB-1:0] model_apply(input logic [NB-1:0] bank, input logic [CW-1:0] c);
        logic [NB-1:0] mask;
        int idx;
        idx = int'(c[IW-1:0]);
        if (c[CW-1])       mask = '1;
        else if (idx < NB) mask = NB'(1) << idx;
        else               mask = '0;
        case (c[CW-2 -: 2])
            2'b01:   return bank & ~mask;
            2'b10:   return bank | mask;
            2'b11:   return bank ^ mask;
            default: return bank;
        endcase
    endfunction

    function automatic bit model_err(input logic [CW-1:0] c);
        return !c[CW-1] && (int'(c[IW-1:0]) >= NB);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bank  = '0;
        m_last  = 1'b1;
        m_phase = 0;
        m_own   = 1'b0;
        m_cmd   = '0;
        m_gnt   = 2'b00;
    endtask

    // One clock cycle: compare DUT outputs with the model mid-cycle, then
    // advance the model across the rising edge. Returns at posedge+1.
    task automatic cycle();
        @(negedge clk);
        m_gnt = 2'b00;
        if (m_phase == 0) begin
            case (req_valid)
                2'b01:   m_gnt = 2'b01;
                2'b10:   m_gnt = 2'b10;
                2'b11:   m_gnt = m_last ? 2'b01 : 2'b10;
                default: m_gnt = 2'b00;
            endcase
        end
        obs_ready = req_ready;
        if (req_ready != 2'b00) obs_log.push_back(req_ready);
        chk("ready", req_ready, m_gnt);
        chk("busy",  busy, (m_phase != 0));
        chk("q",     q, m_bank);
        chk("done",  done, (m_phase == 2) ? (m_own ? 2'b10 : 2'b01) : 2'b00);
        chk("err",   err, (m_phase == 2) && model_err(m_cmd));
        @(posedge clk);
        case (m_phase)
            0: if (m_gnt != 2'b00) begin
                   m_own   = m_gnt[1];
                   m_last  = m_gnt[1];
                   m_cmd   = m_gnt[1] ? req_cmd1 : req_cmd0;
                   m_phase = 1;
               end
            1: begin
                   m_bank  = model_apply(m_bank, m_cmd);
                   m_phase = 2;
               end
            default: m_phase = 0;
        endcase
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        #1;
        chk("rst busy", busy, 1'b0);
        chk("rst q",    q, '0);
        chk("rst done", done, 2'b00);
        chk("rst err",  err, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NB-1:0] exp_q[4];
        logic [1:0]    exp_g[4];
        int            hs;

        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_cmd0  = '0;
        req_cmd1  = '0;
        model_reset();
        obs_ready = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset q",     q, '0);
        chk("reset busy",  busy, 1'b0);
        chk("reset done",  done, 2'b00);
        chk("reset err",   err, 1'b0);
        chk("reset ready", req_ready, 2'b00);
        rst_n = 1'b1;

        // Single set of bit 3 from requester 0.
        req_valid = 2'b01;
        req_cmd0  = mk(0, 1, 0, 3);
        #1;
        chk("t1 ready", req_ready, 2'b01);
        cycle();
        req_valid = 2'b00;
        cycle();
        chk("t1 q",    q, 8'h08);
        chk("t1 done", done, 2'b01);
        chk("t1 err",  err, 1'b0);
        cycle();

        // Both valid continuously from reset, toggling bits 0 and 1.
        do_reset();
        exp_q = '{8'h01, 8'h03, 8'h02, 8'h00};
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        obs_log.delete();
        req_valid = 2'b11;
        req_cmd0  = mk(0, 1, 1, 0);
        req_cmd1  = mk(0, 1, 1, 1);
        for (int n = 0; n < 4; n++) begin
            cycle();
            cycle();
            chk("t2 q",    q, exp_q[n]);
            chk("t2 done", done, exp_g[n]);
            cycle();
        end
        req_valid = 2'b00;
        chk("t2 ngrants", obs_log.size(), 4);
        for (int n = 0; n < 4 && n < obs_log.size(); n++) chk("t2 grant", obs_log[n], exp_g[n]);

        // Broadcast set then broadcast toggle from requester 1.
        req_valid = 2'b10;
        req_cmd1  = mk(1, 1, 0, 0);
        cycle();
        req_valid = 2'b00;
        cycle();
        chk("t3 set q",    q, 8'hFF);
        chk("t3 set done", done, 2'b10);
        cycle();
        req_valid = 2'b10;
        req_cmd1  = mk(1, 1, 1, 0);
        cycle();
        req_valid = 2'b00;
        cycle();
        chk("t3 tgl q",    q, 8'h00);
        chk("t3 tgl done", done, 2'b10);
        cycle();

        // Out-of-range index: no bit changes, err flagged.
        req_valid = 2'b01;
        req_cmd0  = mk(0, 1, 0, 9);
        cycle();
        req_valid = 2'b00;
        cycle();
        chk("t4 q",    q, 8'h00);
        chk("t4 done", done, 2'b01);
        chk("t4 err",  err, 1'b1);
        cycle();

        // Reset during APPLY of a set-bit-5 command (bank non-zero first).
        req_valid = 2'b01;
        req_cmd0  = mk(0, 1, 0, 0);
        cycle();
        req_valid = 2'b00;
        cycle();
        cycle();
        req_valid = 2'b01;
        req_cmd0  = mk(0, 1, 0, 5);
        cycle();
        req_valid = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5 q async",    q, 8'h00);
        chk("t5 busy async", busy, 1'b0);
        chk("t5 done async", done, 2'b00);
        @(posedge clk);
        #1;
        chk("t5 q held",    q, 8'h00);
        chk("t5 done held", done, 2'b00);
        rst_n = 1'b1;
        model_reset();
        req_valid = 2'b11;
        req_cmd0  = mk(0, 0, 0, 0);
        req_cmd1  = mk(0, 1, 0, 7);
        #1;
        chk("t5 tie ready", req_ready, 2'b01);
        cycle();
        req_valid = 2'b10;
        cycle();
        cycle();
        cycle();
        req_valid = 2'b00;
        cycle();
        chk("t5 pending q", q, 8'h80);
        cycle();

        // req0 held valid across busy: one handshake per three cycles.
        hs        = 0;
        req_valid = 2'b01;
        req_cmd0  = mk(0, 1, 0, 2);
        for (int c = 0; c < 9; c++) begin
            cycle();
            if (obs_ready[0]) begin
                hs++;
                req_cmd0 = mk(0, 1, 0, 2 + 2 * hs);
            end
        end
        req_valid = 2'b00;
        chk("t6 handshakes", hs, 3);
        chk("t6 q", q, 8'hD4);
        cycle();

        // Randomized traffic against the model.
        for (int c = 0; c < 300; c++) begin
            cycle();
            if (m_gnt[0]) begin
                req_valid[0] = 1'($urandom_range(0, 1));
                req_cmd0     = rand_cmd();
            end else if (!req_valid[0] && $urandom_range(0, 2) == 0) begin
                req_valid[0] = 1'b1;
                req_cmd0     = rand_cmd();
            end
            if (m_gnt[1]) begin
                req_valid[1] = 1'($urandom_range(0, 1));
                req_cmd1     = rand_cmd();
            end else if (!req_valid[1] && $urandom_range(0, 2) == 0) begin
                req_valid[1] = 1'b1;
                req_cmd1     = rand_cmd();
            end
        end
        req_valid = 2'b00;
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
